// File: rtl/wb_arbiter_rr_pkg.sv
// Shared constants for the writeback arbiter: functional-unit ids
// and a constant-evaluable clog2 used for parameter-derived widths.
package wb_arbiter_rr_pkg;

    localparam int UNIT_ALUMISC = 0;
    localparam int UNIT_MEM     = 1;
    localparam int UNIT_MULT    = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_unit_fifo.sv
// Small per-unit result FIFO: registered head, count, full and empty.
// Storage is not reset; only pointers and count are.
module wb_unit_fifo
    import wb_arbiter_rr_pkg::*;
#(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin writeback arbiter: per-unit FIFOs feed one register-file
// write port, one retirement per cycle, with sticky drop detection.
module wb_arbiter_rr
    import wb_arbiter_rr_pkg::*;
#(
    parameter int NUM_UNITS = UNIT_MULT + 1,
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_UNITS-1:0]        unit_oper,
    input  logic [NUM_UNITS-1:0]        unit_writereg,
    input  logic [NUM_UNITS*REG_AW-1:0] unit_regdest,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_wbvalue,
    output logic [NUM_UNITS-1:0]        unit_ready,
    output logic                        wb_reg_en,
    output logic [REG_AW-1:0]           wb_reg_addr,
    output logic [DATA_W-1:0]           wb_reg_data,
    output logic                        wb_done,
    output logic [clog2(NUM_UNITS)-1:0] wb_unit_id,
    output logic                        buf_overflow
);

    localparam int UW = clog2(NUM_UNITS);
    localparam int FW = 1 + REG_AW + DATA_W;
    localparam int CW = clog2(BUF_DEPTH) + 1;

    logic [FW-1:0]        head [NUM_UNITS];
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] empty;
    logic [UW-1:0]        ptr;
    logic [UW-1:0]        winner;
    logic                 grant;
    logic [FW-1:0]        sel;

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_fifo
        logic [CW-1:0] count;

        // Ready comes from the registered count, never from a same-cycle pop
        assign unit_ready[gi] = (count < CW'(BUF_DEPTH));
        assign push[gi]       = unit_oper[gi] && unit_ready[gi];

        wb_unit_fifo #(
            .WIDTH (FW),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .wdata ({unit_writereg[gi],
                     unit_regdest[gi*REG_AW +: REG_AW],
                     unit_wbvalue[gi*DATA_W +: DATA_W]}),
            .head  (head[gi]),
            .count (count),
            .full  (full[gi]),
            .empty (empty[gi])
        );
    end

    always_comb begin : arb
        int idx;
        idx    = 0;
        grant  = 1'b0;
        winner = ptr;
        for (int k = 1; k <= NUM_UNITS; k++) begin
            idx = (int'(ptr) + k) % NUM_UNITS;
            if (!grant && !empty[idx]) begin
                grant  = 1'b1;
                winner = UW'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant) begin
            pop[winner] = 1'b1;
        end
    end

    assign sel = head[winner];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr          <= UW'(NUM_UNITS - 1);
            wb_reg_en    <= 1'b0;
            wb_reg_addr  <= '0;
            wb_reg_data  <= '0;
            wb_done      <= 1'b0;
            wb_unit_id   <= '0;
            buf_overflow <= 1'b0;
        end else begin
            if (|(unit_oper & full)) begin
                buf_overflow <= 1'b1;
            end
            wb_done <= grant;
            if (grant) begin
                ptr         <= winner;
                wb_unit_id  <= winner;
                wb_reg_addr <= sel[DATA_W +: REG_AW];
                wb_reg_data <= sel[DATA_W-1:0];
                wb_reg_en   <= sel[FW-1] &&
                               (sel[DATA_W +: REG_AW] != '0);
            end else begin
                wb_reg_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr with per-unit expected-result queues
// and a small occupancy model for ready and drop prediction.
module tb_wb_arbiter_rr;
    import wb_arbiter_rr_pkg::*;

    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]    unit_oper;
    logic [N-1:0]    unit_writereg;
    logic [N*AW-1:0] unit_regdest;
    logic [N*DW-1:0] unit_wbvalue;
    logic [N-1:0]    unit_ready;
    logic            wb_reg_en;
    logic [AW-1:0]   wb_reg_addr;
    logic [DW-1:0]   wb_reg_data;
    logic            wb_done;
    logic [1:0]      wb_unit_id;
    logic            buf_overflow;

    always #5 clock = ~clock;

    wb_arbiter_rr #(
        .NUM_UNITS (N),
        .DATA_W    (DW),
        .REG_AW    (AW),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .unit_oper     (unit_oper),
        .unit_writereg (unit_writereg),
        .unit_regdest  (unit_regdest),
        .unit_wbvalue  (unit_wbvalue),
        .unit_ready    (unit_ready),
        .wb_reg_en     (wb_reg_en),
        .wb_reg_addr   (wb_reg_addr),
        .wb_reg_data   (wb_reg_data),
        .wb_done       (wb_done),
        .wb_unit_id    (wb_unit_id),
        .buf_overflow  (buf_overflow)
    );

    int checks   = 0;
    int failures = 0;

    logic [37:0] sb0[$];
    logic [37:0] sb1[$];
    logic [37:0] sb2[$];
    int          cnt      [N];
    logic        pend     [N];
    logic [37:0] pend_exp [N];
    int          last_ret [N];
    logic        exp_ovf;
    int          order[$];
    int          cyc_n = 0;
    logic [N-1:0] seen_low;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sb_total();
        return sb0.size() + sb1.size() + sb2.size();
    endfunction

    task automatic sb_push(input int u, input logic [37:0] e);
        case (u)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            2: sb2.push_back(e);
            default: ;
        endcase
    endtask

    task automatic sb_pop(input int u, output logic ok,
                          output logic [37:0] e);
        ok = 1'b0;
        e  = '0;
        case (u)
            0: if (sb0.size() > 0) begin ok = 1'b1; e = sb0.pop_front(); end
            1: if (sb1.size() > 0) begin ok = 1'b1; e = sb1.pop_front(); end
            2: if (sb2.size() > 0) begin ok = 1'b1; e = sb2.pop_front(); end
            default: ;
        endcase
    endtask

    task automatic clear_model();
        sb0.delete();
        sb1.delete();
        sb2.delete();
        order.delete();
        for (int i = 0; i < N; i++) begin
            cnt[i]      = 0;
            pend[i]     = 1'b0;
            pend_exp[i] = '0;
            last_ret[i] = -100;
        end
        exp_ovf  = 1'b0;
        seen_low = '0;
    endtask

    task automatic clear_inputs();
        unit_oper     = '0;
        unit_writereg = '0;
        unit_regdest  = '0;
        unit_wbvalue  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        clear_model();
    endtask

    task automatic drive(input int u, input logic wr,
                         input logic [AW-1:0] rd, input logic [DW-1:0] val);
        unit_oper[u]            = 1'b1;
        unit_writereg[u]        = wr;
        unit_regdest[u*AW +: AW] = rd;
        unit_wbvalue[u*DW +: DW] = val;
        pend[u]     = 1'b1;
        pend_exp[u] = {wr && (rd != '0), rd, val};
    endtask

    // One clock: commit accepted pushes, then check the retired result
    task automatic cyc();
        logic [N-1:0] acc;
        logic [N-1:0] er;
        logic [37:0]  e;
        logic         ok;
        int           id;
        for (int i = 0; i < N; i++) begin
            acc[i] = pend[i] && (cnt[i] < DEPTH);
            if (pend[i] && !acc[i]) exp_ovf = 1'b1;
        end
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                cnt[i]++;
                sb_push(i, pend_exp[i]);
            end
        end
        #1;
        clear_inputs();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        cyc_n++;
        if (wb_done) begin
            id = int'(wb_unit_id);
            order.push_back(id);
            sb_pop(id, ok, e);
            chk("sb_has_entry", ok, 1);
            if (ok) begin
                chk("wb_fields", {wb_reg_en, wb_reg_addr, wb_reg_data}, e);
                cnt[id]--;
                last_ret[id] = cyc_n;
            end
        end else begin
            chk("idle_en", wb_reg_en, 0);
        end
        for (int i = 0; i < N; i++) er[i] = (cnt[i] < DEPTH);
        chk("unit_ready", unit_ready, er);
        chk("overflow", buf_overflow, exp_ovf);
        seen_low |= ~unit_ready;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb_total() > 0; k++) cyc();
        cyc();
        chk("drained", sb_total(), 0);
    endtask

    initial begin
        int push_c;
        reset = 1'b1;
        clear_inputs();
        clear_model();
        do_reset();

        // Reset state and idle
        chk("rst_done", wb_done, 0);
        chk("rst_en", wb_reg_en, 0);
        chk("rst_addr", wb_reg_addr, 0);
        chk("rst_data", wb_reg_data, 0);
        chk("rst_id", wb_unit_id, 0);
        chk("rst_ovf", buf_overflow, 0);
        chk("rst_ready", unit_ready, 3'b111);
        repeat (6) begin
            cyc();
            chk("idle_done", wb_done, 0);
        end
        chk("idle_no_retire", order.size(), 0);

        // Single result latency
        drive(UNIT_ALUMISC, 1'b1, 5'd3, 32'hDEADBEEF);
        cyc();
        chk("lat_e0_done", wb_done, 0);
        cyc();
        chk("lat_done", wb_done, 1);
        chk("lat_id", wb_unit_id, 0);
        chk("lat_en", wb_reg_en, 1);
        chk("lat_addr", wb_reg_addr, 3);
        chk("lat_data", wb_reg_data, 32'hDEADBEEF);
        cyc();
        chk("lat_one_cycle", wb_done, 0);

        // Three simultaneous pushes retire in unit order
        do_reset();
        drive(UNIT_ALUMISC, 1'b1, 5'd1, 32'h11);
        drive(UNIT_MEM,     1'b1, 5'd2, 32'h22);
        drive(UNIT_MULT,    1'b1, 5'd3, 32'h33);
        repeat (4) cyc();
        chk("rr_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("rr_first", order[0], 0);
            chk("rr_second", order[1], 1);
            chk("rr_third", order[2], 2);
        end

        // Fairness: unit 2 is not starved by a busy unit 0
        drive(UNIT_ALUMISC, 1'b1, 5'd4, 32'hA0);
        drive(UNIT_MULT,    1'b1, 5'd6, 32'hC0);
        cyc();
        push_c = cyc_n;
        for (int k = 1; k <= 4; k++) begin
            if (cnt[0] < DEPTH)
                drive(UNIT_ALUMISC, 1'b1, 5'd4, 32'hA0 + k);
            cyc();
        end
        chk("fair_u2", (last_ret[2] - push_c) <= 3, 1);
        drain();

        // Writes to r0 and non-writing results still retire
        drive(UNIT_MEM, 1'b1, 5'd0, 32'h55);
        cyc();
        cyc();
        chk("r0_done", wb_done, 1);
        chk("r0_id", wb_unit_id, 1);
        chk("r0_en", wb_reg_en, 0);
        drive(UNIT_MULT, 1'b0, 5'd7, 32'h77);
        cyc();
        cyc();
        chk("nowr_done", wb_done, 1);
        chk("nowr_id", wb_unit_id, 2);
        chk("nowr_en", wb_reg_en, 0);

        // Backpressure: two units saturate, then a forced drop
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (cnt[0] < DEPTH) drive(UNIT_ALUMISC, 1'b1, 5'd8, 32'h1000 + k);
            if (cnt[1] < DEPTH) drive(UNIT_MEM, 1'b1, 5'd9, 32'h2000 + k);
            cyc();
        end
        chk("fill_low_u0", seen_low[0], 1);
        chk("fill_low_u1", seen_low[1], 1);
        chk("fill_no_ovf", buf_overflow, 0);
        if (cnt[0] == DEPTH) drive(UNIT_ALUMISC, 1'b1, 5'd10, 32'hBADBAD00);
        else drive(UNIT_MEM, 1'b1, 5'd10, 32'hBADBAD00);
        cyc();
        chk("drop_ovf", buf_overflow, 1);
        drain();
        chk("ovf_sticky", buf_overflow, 1);

        // Asynchronous reset with results queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int u = 0; u < N; u++) begin
                if (cnt[u] < DEPTH) drive(u, 1'b1, 5'(u + 1), 32'hC00 + k);
            end
            cyc();
        end
        chk("pre_rst_done", wb_done, 1);
        chk("pre_rst_queued", sb_total() >= 4, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_done", wb_done, 0);
        chk("arst_en", wb_reg_en, 0);
        chk("arst_addr", wb_reg_addr, 0);
        chk("arst_data", wb_reg_data, 0);
        chk("arst_id", wb_unit_id, 0);
        chk("arst_ready", unit_ready, 3'b111);
        #2 reset = 1'b0;
        clear_model();
        repeat (6) cyc();
        chk("arst_no_retire", order.size(), 0);
        chk("arst_ready_after", unit_ready, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
